uart_tx_fifo_drain: RTL and testbench

//  Drains bytes from a show-ahead byte FIFO and transmits them on the UART TX line as 8N1 frames.
//  The FIFO read-side interface is rd_en/rd_data/valid. Data is sent LSB first.

---
 rtl/uart_tx_fifo_drain.sv | 160 ++++++++++++++++
 tb/tb_uart_tx_fifo_drain.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo_drain.sv
// uart_tx_fifo_drain: pops bytes from a show-ahead FIFO and sends them as 8N1
// UART frames, LSB first. Back-to-back frames have no idle gap.
// Optional macro UART_TX_PARITY_EN inserts a parity bit (even, or odd when
// PARITY_ODD=1) between the data bits and the stop bit.
module uart_tx_fifo_drain #(
    parameter int unsigned CLK_FREQ_HZ = 100_000_000,
    parameter int unsigned BAUD        = 115_200,
    parameter int unsigned PARITY_ODD  = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       fifo_valid,
    input  logic [7:0] fifo_data,
    output logic       fifo_rd_en,
    input  logic       tx_enable,
    output logic       tx,
    output logic       busy,
    output logic       tx_done
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;
    localparam int unsigned CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    // Reject parameter sets the bit timing or parity logic cannot honour
    if (CLKS_PER_BIT < 2 || PARITY_ODD > 1) begin : g_param_check
        $error("uart_tx_fifo_drain: CLKS_PER_BIT must be >= 2 and PARITY_ODD must be 0 or 1");
    end

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [2:0]       bit_idx, bit_idx_n;
    logic [7:0]       shreg, shreg_n;
    logic             tx_n, busy_n, tx_done_n;
    logic             bit_end;
`ifdef UART_TX_PARITY_EN
    logic             par_bit, par_bit_n;
`endif

    // Next-state, bit timing, pop strobe and next values of the registered outputs
    always_comb begin
        state_n    = state;
        bit_idx_n  = bit_idx;
        shreg_n    = shreg;
        fifo_rd_en = 1'b0;
        bit_end    = (cnt == CNT_LAST);
        cnt_n      = bit_end ? '0 : cnt + CNT_W'(1);
`ifdef UART_TX_PARITY_EN
        par_bit_n  = par_bit;
`endif

        case (state)
            IDLE: begin
                cnt_n = '0;
                if (fifo_valid && tx_enable) begin
                    fifo_rd_en = 1'b1;
                    state_n    = START;
                    shreg_n    = fifo_data;
`ifdef UART_TX_PARITY_EN
                    par_bit_n  = (^fifo_data) ^ 1'(PARITY_ODD);
`endif
                end
            end
            START: begin
                if (bit_end) begin
                    state_n   = DATA;
                    bit_idx_n = 3'd0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shreg_n   = {1'b0, shreg[7:1]};
                    bit_idx_n = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_n = STOP;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    if (fifo_valid && tx_enable) begin
                        // Chain straight into the next frame's start bit
                        fifo_rd_en = 1'b1;
                        state_n    = START;
                        shreg_n    = fifo_data;
`ifdef UART_TX_PARITY_EN
                        par_bit_n  = (^fifo_data) ^ 1'(PARITY_ODD);
`endif
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase

        // Line level for the state being entered, so tx is registered without lag
        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shreg_n[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_n = par_bit_n;
`endif
            default: tx_n = 1'b1;
        endcase

        busy_n    = (state_n != IDLE);
        tx_done_n = (state_n == STOP) && (cnt_n == CNT_LAST);
    end

    // State, counters, shift register and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= 3'd0;
            shreg   <= 8'h00;
            tx      <= 1'b1;
            busy    <= 1'b0;
            tx_done <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_bit <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_idx_n;
            shreg   <= shreg_n;
            tx      <= tx_n;
            busy    <= busy_n;
            tx_done <= tx_done_n;
`ifdef UART_TX_PARITY_EN
            par_bit <= par_bit_n;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Testbench for uart_tx_fifo_drain: FIFO model feeds bytes, a line monitor
// decodes frames off tx and checks them against a scoreboard of loaded bytes.
module tb_uart_tx_fifo_drain;

    localparam int unsigned CLK_FREQ_HZ = 1_600_000;
    localparam int unsigned BAUD        = 100_000;
    localparam int unsigned PARITY_ODD  = 0;
    localparam int unsigned CPB         = 16;
`ifdef UART_TX_PARITY_EN
    localparam int unsigned NBITS = 11;
`else
    localparam int unsigned NBITS = 10;
`endif
    localparam int unsigned FRAME = NBITS * CPB;

    logic       clk = 1'b0;
    logic       rst;
    logic       fifo_valid;
    logic [7:0] fifo_data;
    logic       fifo_rd_en;
    logic       tx_enable;
    logic       tx;
    logic       busy;
    logic       tx_done;

    uart_tx_fifo_drain #(
        .CLK_FREQ_HZ (CLK_FREQ_HZ),
        .BAUD        (BAUD),
        .PARITY_ODD  (PARITY_ODD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_valid (fifo_valid),
        .fifo_data  (fifo_data),
        .fifo_rd_en (fifo_rd_en),
        .tx_enable  (tx_enable),
        .tx         (tx),
        .busy       (busy),
        .tx_done    (tx_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] fifo_q[$];
    logic [7:0] exp_q[$];

    int cyc         = 0;
    int rd_count    = 0;
    int done_count  = 0;
    int busy_cycles = 0;
    int rd_bad      = 0;
    int frames      = 0;
    int rst_events  = 0;
    int launch_t[$];
    int done_t[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic load(input logic [7:0] b);
        fifo_q.push_back(b);
        exp_q.push_back(b);
    endtask

    // Event log sampled mid-cycle
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (fifo_rd_en) begin
            rd_count <= rd_count + 1;
            launch_t.push_back(cyc);
            if (!fifo_valid) rd_bad <= rd_bad + 1;
        end
        if (tx_done) begin
            done_count <= done_count + 1;
            done_t.push_back(cyc);
        end
        if (busy) busy_cycles <= busy_cycles + 1;
    end

    always @(posedge rst) rst_events <= rst_events + 1;

    // Show-ahead FIFO model: pops on a cycle where rd_en was seen
    logic rd_seen;
    initial begin
        fifo_valid = 1'b0;
        fifo_data  = 8'h00;
        forever begin
            @(negedge clk);
            rd_seen = fifo_rd_en;
            @(posedge clk);
            #1;
            if (rd_seen && fifo_q.size() > 0) void'(fifo_q.pop_front());
            fifo_valid = (fifo_q.size() > 0);
            fifo_data  = fifo_valid ? fifo_q[0] : 8'h00;
        end
    end

    // Line monitor: decodes frames at bit centres and scores them
    logic [7:0] mon_b;
    logic [7:0] mon_e;
    logic       mon_s0;
    logic       mon_stop;
    logic       mon_par;
    int         mon_rc;
    initial begin
        mon_par = 1'b0;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && tx === 1'b0) begin
                mon_rc = rst_events;
                repeat (CPB / 2) @(negedge clk);
                mon_s0 = tx;
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    mon_b[i] = tx;
                end
`ifdef UART_TX_PARITY_EN
                repeat (CPB) @(negedge clk);
                mon_par = tx;
`endif
                repeat (CPB) @(negedge clk);
                mon_stop = tx;
                if (mon_rc == rst_events) begin
                    frames++;
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL frame_unexpected: got byte 0x%02h, expected no frame", mon_b);
                    end else begin
                        mon_e = exp_q.pop_front();
                        check("frame_byte", 32'(mon_b), 32'(mon_e));
                        check("frame_start_stop", 32'({mon_s0, mon_stop}), 32'(2'b01));
`ifdef UART_TX_PARITY_EN
                        check("frame_parity", 32'(mon_par), 32'((^mon_e) ^ 1'(PARITY_ODD)));
`endif
                    end
                end
            end
        end
    end

    task automatic wait_launch(input string name);
        bit hit = 1'b0;
        for (int k = 0; k < 400 && !hit; k++) begin
            @(negedge clk);
            if (fifo_rd_en === 1'b1) hit = 1'b1;
        end
        if (!hit) begin
            n_checks++;
            $display("FAIL %s: got no fifo_rd_en, expected a launch", name);
        end
    endtask

    task automatic wait_done(input int target, input int budget, input string name);
        int k = 0;
        while (done_count < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (done_count < target) begin
            n_checks++;
            $display("FAIL %s: got %0d tx_done pulses, expected %0d", name, done_count, target);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected test completion");
        $fatal(1, "watchdog");
    end

    int         r0;
    int         d0;
    int         b0;
    int         li;
    int         di;
    int         mism;
    int         done_k;
    int         ndone;
    int         tx_low;
    logic [10:0] fb;

    initial begin
        rst       = 1'b1;
        tx_enable = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        repeat (5) @(posedge clk);

        // 1: reset asserted while idle
        #3 rst = 1'b1;
        #1;
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        check("rst_tx_done", 32'(tx_done), 32'd0);
        @(posedge clk);
        #2 rst = 1'b0;
        tx_enable = 1'b1;
        repeat (3) @(posedge clk);

        // 2: single byte 0xA5, exact line waveform and tx_done position
        #2;
        r0 = rd_count;
        load(8'hA5);
        wait_launch("launch_a5");
        fb = 11'h7FF;
        fb[0]   = 1'b0;
        fb[8:1] = 8'hA5;
`ifdef UART_TX_PARITY_EN
        fb[9]   = (^8'hA5) ^ 1'(PARITY_ODD);
`endif
        mism = 0; done_k = 0; ndone = 0;
        for (int k = 1; k <= int'(FRAME); k++) begin
            @(negedge clk);
            if (tx !== fb[(k - 1) / int'(CPB)]) mism++;
            if (tx_done) begin done_k = k; ndone++; end
        end
        check("a5_tx_pattern_errs", 32'(mism), 32'd0);
        check("a5_tx_done_cycle", 32'(done_k), 32'(FRAME));
        check("a5_tx_done_pulses", 32'(ndone), 32'd1);
        repeat (3) @(negedge clk);
        check("a5_rd_pulses", 32'(rd_count - r0), 32'd1);
        check("a5_busy_after", 32'(busy), 32'd0);

        // 3: two bytes back to back, no idle gap
        @(posedge clk); #2;
        r0 = rd_count; d0 = done_count; b0 = busy_cycles;
        li = launch_t.size(); di = done_t.size();
        load(8'h00);
        load(8'hFF);
        wait_done(d0 + 2, 3 * FRAME, "b2b_done");
        repeat (4) @(negedge clk);
        check("b2b_rd_pulses", 32'(rd_count - r0), 32'd2);
        if (launch_t.size() >= li + 2 && done_t.size() >= di + 1) begin
            check("b2b_launch_spacing", 32'(launch_t[li + 1] - launch_t[li]), 32'(FRAME));
            check("b2b_relaunch_at_done", 32'(launch_t[li + 1] - done_t[di]), 32'd0);
        end else begin
            n_checks++;
            $display("FAIL b2b_log: got %0d launches, expected 2", launch_t.size() - li);
        end
        check("b2b_busy_cycles", 32'(busy_cycles - b0), 32'(2 * FRAME));

        // 4: flow control dropped mid-frame
        @(posedge clk); #2;
        r0 = rd_count; d0 = done_count;
        load(8'h3C);
        load(8'h81);
        wait_launch("launch_3c");
        repeat (40) @(posedge clk);
        #2 tx_enable = 1'b0;
        wait_done(d0 + 1, 2 * FRAME, "fc_done");
        tx_low = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (tx !== 1'b1) tx_low++;
        end
        check("fc_rd_pulses_held", 32'(rd_count - r0), 32'd1);
        check("fc_tx_low_cycles", 32'(tx_low), 32'd0);
        check("fc_busy_held", 32'(busy), 32'd0);
        @(posedge clk);
        #2 tx_enable = 1'b1;
        wait_done(d0 + 2, 2 * FRAME, "fc_resume_done");
        repeat (4) @(negedge clk);
        check("fc_rd_pulses_resumed", 32'(rd_count - r0), 32'd2);

        // 5: async reset during data bit 4 of 0x6F (bit 4 = 0)
        @(posedge clk); #2;
        load(8'h6F);
        wait_launch("launch_6f");
        repeat (85) @(posedge clk);
        #2;
        check("abort_pre_tx_bit4", 32'(tx), 32'd0);
        #1 rst = 1'b1;
        #1;
        check("abort_tx", 32'(tx), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_rd_en", 32'(fifo_rd_en), 32'd0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        void'(exp_q.pop_front());
        repeat (200) @(posedge clk);
        #2;
        d0 = done_count;
        load(8'hC3);
        wait_done(d0 + 1, 2 * FRAME, "post_abort_done");
        repeat (20) @(negedge clk);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        check("frames_seen", 32'(frames), 32'd6);
        check("rd_en_without_valid", 32'(rd_bad), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
